// File: rtl/iagc_pkg.sv
// Shared IAGC definitions: default widths, controller status codes,
// host command codes and the memory sequencer state type.
package iagc_pkg;

  localparam int IAGC_ADDR_SIZE      = 12;
  localparam int IAGC_DATA_SIZE      = 14;
  localparam int IAGC_DECIMATOR_SIZE = 4;
  localparam int IAGC_STATUS_SIZE    = 4;

  // Controller status codes. The sequencer only acts on SAMPLE,
  // DUMP_REF, DUMP_ERR and CLEAN_MEM. Every other code is passive.
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_RESET       = 4'd0;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_IDLE        = 4'd1;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_WAIT_TRIG   = 4'd2;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_SAMPLE      = 4'd3;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_SAMPLE_DONE = 4'd4;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_LIVE        = 4'd5;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_WAIT_CMD    = 4'd6;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_DUMP_REF    = 4'd7;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_DUMP_ERR    = 4'd8;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_CLEAN_MEM   = 4'd9;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_CLEAN_DONE  = 4'd10;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_DUMP_DONE   = 4'd11;
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_ERROR       = 4'd12;

  // Host command bytes decoded by the controller.
  localparam logic [7:0] CMD_RESET    = 8'h00;
  localparam logic [7:0] CMD_SAMPLE   = 8'h01;
  localparam logic [7:0] CMD_DUMP_REF = 8'h02;
  localparam logic [7:0] CMD_DUMP_ERR = 8'h03;
  localparam logic [7:0] CMD_CLEAN    = 8'h04;
  localparam logic [7:0] CMD_LIVE     = 8'h05;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_SAMPLE,
    SEQ_CLEAN,
    SEQ_DUMP_RD,
    SEQ_DUMP_WAIT,
    SEQ_DUMP_TX,
    SEQ_DONE
  } seq_state_e;

  // True while an operation owns the memory and can still be aborted.
  function automatic logic seq_active(input seq_state_e s);
    return (s == SEQ_SAMPLE) || (s == SEQ_CLEAN) || (s == SEQ_DUMP_RD) ||
           (s == SEQ_DUMP_WAIT) || (s == SEQ_DUMP_TX);
  endfunction

endpackage

// File: rtl/iagc_mem_sequencer_if.sv
// Sample memory port plus the transmitter stream, as seen by the sequencer.
interface iagc_mem_sequencer_if
  import iagc_pkg::*;
#(
  parameter int ADDR_SIZE = IAGC_ADDR_SIZE,
  parameter int DATA_SIZE = IAGC_DATA_SIZE
);
  logic                 mem_we;
  logic                 mem_re;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata_ref;
  logic [DATA_SIZE-1:0] mem_wdata_err;
  logic [DATA_SIZE-1:0] mem_rdata_ref;
  logic [DATA_SIZE-1:0] mem_rdata_err;
  logic [DATA_SIZE-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output mem_we, mem_re, mem_addr, mem_wdata_ref, mem_wdata_err, tx_data, tx_valid,
    input  mem_rdata_ref, mem_rdata_err, tx_ready
  );

  modport slave (
    input  mem_we, mem_re, mem_addr, mem_wdata_ref, mem_wdata_err, tx_data, tx_valid,
    output mem_rdata_ref, mem_rdata_err, tx_ready
  );
endinterface

// File: rtl/iagc_decimator.sv
// Keep-1-of-D strobe generator. The first valid after a clear is kept,
// then D-1 valids are skipped. D=0 behaves as D=1.
module iagc_decimator
  import iagc_pkg::*;
#(
  parameter int DECIMATOR_SIZE = IAGC_DECIMATOR_SIZE
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_clear,
  input  logic                      i_enable,
  input  logic [DECIMATOR_SIZE-1:0] i_decimator,
  input  logic                      i_valid,
  output logic                      o_keep
);
  logic [DECIMATOR_SIZE-1:0] r_count;
  logic [DECIMATOR_SIZE-1:0] w_load;

  assign w_load = (i_decimator == '0) ? DECIMATOR_SIZE'(1) : i_decimator;
  assign o_keep = i_enable && i_valid && (r_count == '0);

  // Count skips remaining until the next kept sample.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear)
      r_count <= '0;
    else if (i_enable && i_valid)
      r_count <= (r_count == '0) ? (w_load - DECIMATOR_SIZE'(1)) : (r_count - DECIMATOR_SIZE'(1));
  end
endmodule

// File: rtl/iagc_mem_sequencer.sv
// Sequences the shared ref/err sample memory for the IAGC controller:
// decimated capture, zero-fill and read-out to the UART transmitter.
module iagc_mem_sequencer
  import iagc_pkg::*;
#(
  parameter int ADDR_SIZE      = IAGC_ADDR_SIZE,
  parameter int DATA_SIZE      = IAGC_DATA_SIZE,
  parameter int DECIMATOR_SIZE = IAGC_DECIMATOR_SIZE,
  parameter int STATUS_SIZE    = IAGC_STATUS_SIZE
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [STATUS_SIZE-1:0]    i_status,
  input  logic [ADDR_SIZE:0]        i_memory_size,
  input  logic [DECIMATOR_SIZE-1:0] i_decimator,
  input  logic                      i_adc_valid,
  input  logic [DATA_SIZE-1:0]      i_adc_ref,
  input  logic [DATA_SIZE-1:0]      i_adc_err,
  iagc_mem_sequencer_if.master      bus,
  output logic                      o_sample_end,
  output logic                      o_dump_end,
  output logic                      o_clean_end
);
  seq_state_e                r_state;
  logic [STATUS_SIZE-1:0]    r_code;
  logic [ADDR_SIZE-1:0]      r_addr;
  logic [ADDR_SIZE-1:0]      r_last;
  logic [DECIMATOR_SIZE-1:0] r_dec;
  logic                      r_sel_err;

  logic                      r_mem_we;
  logic                      r_mem_re;
  logic [ADDR_SIZE-1:0]      r_mem_addr;
  logic [DATA_SIZE-1:0]      r_wdata_ref;
  logic [DATA_SIZE-1:0]      r_wdata_err;
  logic [DATA_SIZE-1:0]      r_tx_data;
  logic                      r_tx_valid;
  logic                      r_sample_end;
  logic                      r_dump_end;
  logic                      r_clean_end;

  logic                      w_keep;
  logic                      w_abort;
  logic                      w_at_last;

  iagc_decimator #(.DECIMATOR_SIZE(DECIMATOR_SIZE)) u_decimator (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (r_state == SEQ_IDLE),
    .i_enable    (r_state == SEQ_SAMPLE),
    .i_decimator (r_dec),
    .i_valid     (i_adc_valid),
    .o_keep      (w_keep)
  );

  // Any status change during an operation cancels it without an end pulse.
  assign w_abort   = seq_active(r_state) && (i_status != r_code);
  assign w_at_last = (r_addr == r_last);

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= SEQ_IDLE;
      r_code       <= '0;
      r_addr       <= '0;
      r_last       <= '0;
      r_dec        <= '0;
      r_sel_err    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_addr   <= '0;
      r_wdata_ref  <= '0;
      r_wdata_err  <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_sample_end <= 1'b0;
      r_dump_end   <= 1'b0;
      r_clean_end  <= 1'b0;
    end else begin
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_sample_end <= 1'b0;
      r_dump_end   <= 1'b0;
      r_clean_end  <= 1'b0;
      if (w_abort) begin
        r_state    <= SEQ_IDLE;
        r_tx_valid <= 1'b0;
      end else begin
        case (r_state)
          SEQ_IDLE: begin
            // N and D are re-sampled every idle cycle, so the values seen
            // on the entry cycle are the ones the operation keeps.
            r_addr    <= '0;
            r_code    <= i_status;
            r_last    <= ADDR_SIZE'(i_memory_size - 1'b1);
            r_dec     <= i_decimator;
            r_sel_err <= (i_status == ST_DUMP_ERR);
            case (i_status)
              ST_SAMPLE:    r_state <= SEQ_SAMPLE;
              ST_CLEAN_MEM: r_state <= SEQ_CLEAN;
              ST_DUMP_REF, ST_DUMP_ERR: begin
                // Read is issued on entry so it is live during DUMP_RD.
                r_state    <= SEQ_DUMP_RD;
                r_mem_re   <= 1'b1;
                r_mem_addr <= '0;
              end
              default: r_state <= SEQ_IDLE;
            endcase
          end
          SEQ_SAMPLE: begin
            if (w_keep) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr;
              r_wdata_ref <= i_adc_ref;
              r_wdata_err <= i_adc_err;
              if (w_at_last) begin
                r_sample_end <= 1'b1;
                r_state      <= SEQ_DONE;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end
          end
          SEQ_CLEAN: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_wdata_ref <= '0;
            r_wdata_err <= '0;
            if (w_at_last) begin
              r_clean_end <= 1'b1;
              r_state     <= SEQ_DONE;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
          SEQ_DUMP_RD: r_state <= SEQ_DUMP_WAIT;
          SEQ_DUMP_WAIT: begin
            r_tx_data  <= r_sel_err ? bus.mem_rdata_err : bus.mem_rdata_ref;
            r_tx_valid <= 1'b1;
            r_state    <= SEQ_DUMP_TX;
          end
          SEQ_DUMP_TX: begin
            if (bus.tx_ready) begin
              r_tx_valid <= 1'b0;
              if (w_at_last) begin
                r_dump_end <= 1'b1;
                r_state    <= SEQ_DONE;
              end else begin
                r_addr     <= r_addr + 1'b1;
                r_mem_re   <= 1'b1;
                r_mem_addr <= r_addr + 1'b1;
                r_state    <= SEQ_DUMP_RD;
              end
            end
          end
          SEQ_DONE: begin
            // Hold off until the controller moves on, so the same status
            // cannot retrigger the operation.
            if (i_status != r_code) r_state <= SEQ_IDLE;
          end
          default: r_state <= SEQ_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_we        = r_mem_we;
  assign bus.mem_re        = r_mem_re;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata_ref = r_wdata_ref;
  assign bus.mem_wdata_err = r_wdata_err;
  assign bus.tx_data       = r_tx_data;
  assign bus.tx_valid      = r_tx_valid;
  assign o_sample_end      = r_sample_end;
  assign o_dump_end        = r_dump_end;
  assign o_clean_end       = r_clean_end;
endmodule

// File: tb/tb_iagc_mem_sequencer.sv
// Bench for iagc_mem_sequencer: memory + transmitter models, expected
// write/word queues built from the operation rules, one monitor.
module tb_iagc_mem_sequencer;
  import iagc_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 14;
  localparam int DEPTH = 4096;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic [3:0]    i_status = '0;
  logic [AW:0]   i_memory_size = '0;
  logic [3:0]    i_decimator = '0;
  logic          i_adc_valid = 1'b0;
  logic [DW-1:0] i_adc_ref = '0;
  logic [DW-1:0] i_adc_err = '0;
  logic          o_sample_end, o_dump_end, o_clean_end;

  iagc_mem_sequencer_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

  iagc_mem_sequencer #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DECIMATOR_SIZE(4), .STATUS_SIZE(4)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_status      (i_status),
    .i_memory_size (i_memory_size),
    .i_decimator   (i_decimator),
    .i_adc_valid   (i_adc_valid),
    .i_adc_ref     (i_adc_ref),
    .i_adc_err     (i_adc_err),
    .bus           (bus),
    .o_sample_end  (o_sample_end),
    .o_dump_end    (o_dump_end),
    .o_clean_end   (o_clean_end)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0d", name, act);
  endtask

  // Memory model: synchronous write, 1-cycle read latency; bench preload port.
  logic [DW-1:0] mem_ref [DEPTH];
  logic [DW-1:0] mem_err [DEPTH];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_ref = '0, pre_err = '0;

  always @(posedge i_clock) begin
    if (pre_we) begin
      mem_ref[pre_addr] <= pre_ref;
      mem_err[pre_addr] <= pre_err;
    end else if (bus.mem_we) begin
      mem_ref[bus.mem_addr] <= bus.mem_wdata_ref;
      mem_err[bus.mem_addr] <= bus.mem_wdata_err;
    end
    if (bus.mem_re) begin
      bus.mem_rdata_ref <= mem_ref[bus.mem_addr];
      bus.mem_rdata_err <= mem_err[bus.mem_addr];
    end
  end

  // Expected activity.
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] r; logic [DW-1:0] e; logic [1:0] endp; } wr_t;
  typedef struct { logic [DW-1:0] d; logic last; } tx_t;
  wr_t exp_wr[$];
  tx_t exp_tx[$];

  int hold = 0;          // cycles of valid before the transmitter accepts
  int wcnt = 0;
  int cyc = 0;
  int n_wr = 0, first_wr_cyc = 0, last_wr_cyc = 0;
  int n_sample_end = 0, n_clean_end = 0, n_dump_end = 0;
  int prev_hs_cyc = 0, hs_gap = 0;
  logic dump_pend = 1'b0;
  logic prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Transmitter model and monitor, both on the falling edge.
  always @(negedge i_clock) begin
    wr_t e;
    tx_t t;
    cyc++;
    if (bus.tx_valid) begin
      bus.tx_ready = (wcnt >= hold);
      wcnt++;
    end else begin
      bus.tx_ready = 1'b0;
      wcnt = 0;
    end
    if (!i_reset) begin
      if (o_sample_end) n_sample_end++;
      if (o_clean_end)  n_clean_end++;
      if (o_dump_end)   n_dump_end++;
      if (bus.mem_we) begin
        n_wr++;
        if (n_wr == 1) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        if (exp_wr.size() == 0) fail("unexpected_write_addr", 32'(bus.mem_addr));
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("wr_ref", 32'(bus.mem_wdata_ref), 32'(e.r));
          chk("wr_err", 32'(bus.mem_wdata_err), 32'(e.e));
          chk("wr_end_pulse", 32'({o_sample_end, o_clean_end}), 32'(e.endp));
        end
      end else if (o_sample_end || o_clean_end) begin
        fail("end_pulse_without_write", 32'({o_sample_end, o_clean_end}));
      end
      if (o_dump_end || dump_pend) chk("dump_end", 32'(o_dump_end), 32'(dump_pend));
      dump_pend = 1'b0;
      if (prev_hold && exp_tx.size() > 0) begin
        chk("tx_valid_held", 32'(bus.tx_valid), 32'd1);
        chk("tx_data_held", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        hs_gap = cyc - prev_hs_cyc;
        prev_hs_cyc = cyc;
        if (exp_tx.size() == 0) fail("unexpected_tx_word", 32'(bus.tx_data));
        else begin
          t = exp_tx.pop_front();
          chk("tx_data", 32'(bus.tx_data), 32'(t.d));
          dump_pend = t.last;
        end
      end
      prev_hold = bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
    end
  end

  // Capture rule: the k-th accepted ADC sample is kept when k is a multiple
  // of max(D,1), landing at address k/max(D,1); N writes in total.
  task automatic model_sample(input int n, input int d, input int errbase);
    int dm = (d == 0) ? 1 : d;
    int depth = (n == 0) ? DEPTH : n;
    for (int a = 0; a < depth; a++) begin
      int k = a * dm;
      exp_wr.push_back('{addr: AW'(a), r: DW'(k), e: DW'(errbase + k),
                         endp: (a == depth - 1) ? 2'b10 : 2'b00});
    end
  endtask

  task automatic drive_adc(input int count, input int errbase);
    for (int k = 0; k < count; k++) begin
      i_adc_valid = 1'b1;
      i_adc_ref = DW'(k);
      i_adc_err = DW'(errbase + k);
      @(negedge i_clock);
    end
    i_adc_valid = 1'b0;
  endtask

  task automatic preload(input int a, input int r, input int e);
    pre_we = 1'b1;
    pre_addr = AW'(a);
    pre_ref = DW'(r);
    pre_err = DW'(e);
    @(negedge i_clock);
    pre_we = 1'b0;
  endtask

  task automatic wait_wr_drain(input int limit, input string name);
    int t = 0;
    while (exp_wr.size() > 0 && t < limit) begin @(negedge i_clock); t++; end
    if (exp_wr.size() > 0) fail(name, 32'(exp_wr.size()));
    @(negedge i_clock);
  endtask

  task automatic wait_tx_drain(input int limit, input string name);
    int t = 0;
    while (exp_tx.size() > 0 && t < limit) begin @(negedge i_clock); t++; end
    if (exp_tx.size() > 0) fail(name, 32'(exp_tx.size()));
    repeat (3) @(negedge i_clock);
  endtask

  // Sit in DONE for a while (monitor flags any retrigger), then release.
  task automatic release_status();
    repeat (5) @(negedge i_clock);
    i_status = ST_RESET;
    repeat (3) @(negedge i_clock);
  endtask

  task automatic clr_stats();
    n_wr = 0; n_sample_end = 0; n_clean_end = 0; n_dump_end = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (3) @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_ends", 32'({o_sample_end, o_clean_end, o_dump_end}), 32'd0);

    // Clean N=8; a mid-operation change of N must be ignored.
    clr_stats();
    for (int a = 0; a < 8; a++)
      exp_wr.push_back('{addr: AW'(a), r: '0, e: '0, endp: (a == 7) ? 2'b01 : 2'b00});
    i_memory_size = 8;
    i_status = ST_CLEAN_MEM;
    @(negedge i_clock);
    i_memory_size = 3;
    wait_wr_drain(40, "clean_timeout");
    chk("clean_n_writes", 32'(n_wr), 32'd8);
    chk("clean_back_to_back", 32'(last_wr_cyc - first_wr_cyc), 32'd7);
    chk("clean_end_count", 32'(n_clean_end), 32'd1);
    chk("clean_mem7_ref", 32'(mem_ref[7]), 32'd0);
    release_status();

    // Decimated sample N=4 D=3; N/D changes after entry are ignored.
    clr_stats();
    model_sample(4, 3, 100);
    i_memory_size = 4;
    i_decimator = 3;
    i_status = ST_SAMPLE;
    @(negedge i_clock);
    i_decimator = 1;
    i_memory_size = 2;
    drive_adc(14, 100);
    wait_wr_drain(40, "sample_timeout");
    chk("sample_end_count", 32'(n_sample_end), 32'd1);
    chk("sample_mem1_ref", 32'(mem_ref[1]), 32'd3);
    chk("sample_mem3_ref", 32'(mem_ref[3]), 32'd9);
    chk("sample_mem1_err", 32'(mem_err[1]), 32'd103);
    release_status();

    // Dump ref with 3 cycles of backpressure per word.
    clr_stats();
    preload(0, 5, 900); preload(1, 6, 901); preload(2, 7, 902); preload(3, 8, 903);
    hold = 3;
    exp_tx.push_back('{d: DW'(5), last: 1'b0});
    exp_tx.push_back('{d: DW'(6), last: 1'b0});
    exp_tx.push_back('{d: DW'(7), last: 1'b0});
    exp_tx.push_back('{d: DW'(8), last: 1'b1});
    i_memory_size = 4;
    i_status = ST_DUMP_REF;
    wait_tx_drain(100, "dump_ref_timeout");
    chk("dump_ref_end_count", 32'(n_dump_end), 32'd1);
    release_status();

    // Dump err, ready immediately, with ADC activity that must not write.
    clr_stats();
    preload(0, 50, 1); preload(1, 60, 2);
    hold = 0;
    exp_tx.push_back('{d: DW'(1), last: 1'b0});
    exp_tx.push_back('{d: DW'(2), last: 1'b1});
    i_memory_size = 2;
    i_adc_valid = 1'b1;
    i_adc_ref = 14'd77;
    i_adc_err = 14'd88;
    i_status = ST_DUMP_ERR;
    wait_tx_drain(50, "dump_err_timeout");
    i_adc_valid = 1'b0;
    chk("dump_err_end_count", 32'(n_dump_end), 32'd1);
    chk("dump_word_cycles", 32'(hs_gap), 32'd3);
    chk("dump_err_no_writes", 32'(n_wr), 32'd0);
    release_status();

    // Abort a clean after 5 writes.
    clr_stats();
    for (int a = 0; a < 5; a++)
      exp_wr.push_back('{addr: AW'(a), r: '0, e: '0, endp: 2'b00});
    i_memory_size = 16;
    i_status = ST_CLEAN_MEM;
    cnt = 0;
    for (int t = 0; t < 30 && cnt < 5; t++) begin
      @(negedge i_clock);
      if (bus.mem_we) cnt++;
    end
    if (cnt < 5) fail("abort_wait_timeout", 32'(cnt));
    i_status = ST_RESET;
    @(negedge i_clock);
    chk("abort_we_drop", 32'(bus.mem_we), 32'd0);
    repeat (5) @(negedge i_clock);
    chk("abort_pending_writes", 32'(exp_wr.size()), 32'd0);
    chk("abort_no_clean_end", 32'(n_clean_end), 32'd0);

    // Full depth capture: N encoded as 0, D=0 keeps every sample.
    clr_stats();
    model_sample(0, 0, 5000);
    i_memory_size = 0;
    i_decimator = 0;
    i_status = ST_SAMPLE;
    @(negedge i_clock);
    drive_adc(4100, 5000);
    wait_wr_drain(50, "full_depth_timeout");
    chk("full_n_writes", 32'(n_wr), 32'd4096);
    chk("full_end_count", 32'(n_sample_end), 32'd1);
    chk("full_mem0_ref_no_wrap", 32'(mem_ref[0]), 32'd0);
    chk("full_mem4095_ref", 32'(mem_ref[4095]), 32'd4095);
    chk("full_mem0_err", 32'(mem_err[0]), 32'd5000);
    release_status();

    // Reset in the middle of a dump with a word pending.
    hold = 1000;
    i_memory_size = 4;
    i_status = ST_DUMP_REF;
    cnt = 0;
    while (!bus.tx_valid && cnt < 20) begin @(negedge i_clock); cnt++; end
    chk("rst_dump_valid_seen", 32'(bus.tx_valid), 32'd1);
    i_reset = 1'b1;
    @(negedge i_clock);
    chk("rst_mid_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_mid_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_mid_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_mid_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mid_ends", 32'({o_sample_end, o_clean_end, o_dump_end, bus.mem_we}), 32'd0);
    i_status = ST_RESET;
    @(negedge i_clock);
    i_reset = 1'b0;
    repeat (3) @(negedge i_clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
